// File: rtl/avalon_tri_master_if.sv
// avalon_tri_master_if
//   Avalon-MM bus between the triangle-test master and the triangle-check slave.
//   avm_address[1:0]    master -> slave  word address (0/1/2 operands, 3 result)
//   avm_read            master -> slave  read strobe
//   avm_write           master -> slave  write strobe
//   avm_writedata[31:0] master -> slave  write data
//   avm_waitrequest     slave -> master  stall; a strobe is accepted on an edge where this is low
//   avm_readdata[31:0]  slave -> master  read data (bit 0 is the triangle result)
interface avalon_tri_master_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_waitrequest, avm_readdata
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_waitrequest, avm_readdata
  );
endinterface

// File: rtl/avalon_tri_master.sv
// avalon_tri_master
//   Avalon-MM master running one triangle test: on an accepted start it latches
//   a/b/c, writes them to word addresses 0/1/2 (one idle gap cycle after each
//   write), reads address 3 and returns bit 0 as is_tri.
//
//   Parameters
//     READ_LATENCY   0: readdata sampled on the read accept edge
//                    1: readdata sampled one edge after accept (registered slave)
//     TIMEOUT_CYCLES stalled cycles that abort a transfer (1..255), timeout build only
//
//   Ports
//     clk, reset_n   clock (rising edge), asynchronous active-low reset
//     start          request pulse, only honoured in IDLE
//     a, b, c        32-bit operands, captured with start
//     busy           high from the accept edge of start through the done cycle
//     done           one-cycle completion pulse
//     is_tri         result bit, held until the next done
//     error          last operation timed out, held until the next accepted start
//     avm            Avalon-MM master modport
//
//   Optional feature: define TRI_MASTER_TIMEOUT_EN to add the waitrequest
//   timeout. Without it the master waits forever and error stays 0.
//
//   All bus and status outputs are flops loaded from the next state, so the
//   strobes appear in the cycle after the deciding edge and drop at once on reset.
module avalon_tri_master #(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [31:0]                a,
  input  logic [31:0]                b,
  input  logic [31:0]                c,
  output logic                       busy,
  output logic                       done,
  output logic                       is_tri,
  output logic                       error,
  avalon_tri_master_if.master        avm
);

  typedef enum logic [3:0] {
    IDLE, WR_A, GAP_A, WR_B, GAP_B, WR_C, GAP_C, RD_R, CAP, FIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        is_tri_q, is_tri_d, error_q, error_d;
  logic        read_q, read_d, write_q, write_d;
  logic [1:0]  address_q, address_d;
  logic [31:0] wdata_q, wdata_d;

  logic start_ok_s;
  logic stall_s;
  logic accept_s;
  logic timeout_s;
  logic unused_s;

  assign start_ok_s = (state_q == IDLE) && start;
  assign stall_s    = (read_q | write_q) & avm.avm_waitrequest;
  assign accept_s   = (read_q | write_q) & ~avm.avm_waitrequest;

  // Only bit 0 of the result register carries information.
  assign unused_s   = ^{avm.avm_readdata[31:1], 8'(TIMEOUT_CYCLES)};

`ifdef TRI_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout_s = stall_s && ((tmo_cnt_q + 8'd1) == TMO_LIMIT);

  // Consecutive-stall counter; any cycle without a stalled strobe clears it.
  always_comb begin
    if (stall_s && !timeout_s) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end else begin
      tmo_cnt_d = 8'd0;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= 8'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      c_q       <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      is_tri_q  <= 1'b0;
      error_q   <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      address_q <= 2'd0;
      wdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      is_tri_q  <= is_tri_d;
      error_q   <= error_d;
      read_q    <= read_d;
      write_q   <= write_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
    end
  end

  // Next-state logic; a timeout in any strobe state jumps straight to FIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = WR_A;
        else       state_d = IDLE;
      end
      WR_A: begin
        if (timeout_s)     state_d = FIN;
        else if (accept_s) state_d = GAP_A;
        else               state_d = WR_A;
      end
      GAP_A: state_d = WR_B;
      WR_B: begin
        if (timeout_s)     state_d = FIN;
        else if (accept_s) state_d = GAP_B;
        else               state_d = WR_B;
      end
      GAP_B: state_d = WR_C;
      WR_C: begin
        if (timeout_s)     state_d = FIN;
        else if (accept_s) state_d = GAP_C;
        else               state_d = WR_C;
      end
      GAP_C: state_d = RD_R;
      RD_R: begin
        if (timeout_s)                      state_d = FIN;
        else if (accept_s && (READ_LATENCY == 0)) state_d = FIN;
        else if (accept_s)                  state_d = CAP;
        else                                state_d = RD_R;
      end
      CAP:     state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on an accepted start.
  always_comb begin
    if (start_ok_s) begin
      a_d = a;
      b_d = b;
      c_d = c;
    end else begin
      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
    end
  end

  // Output decode from the next state, plus result/error capture.
  always_comb begin
    read_d    = 1'b0;
    write_d   = 1'b0;
    address_d = 2'd0;
    wdata_d   = 32'd0;
    case (state_d)
      WR_A: begin
        write_d   = 1'b1;
        address_d = 2'd0;
        wdata_d   = a_d;
      end
      WR_B: begin
        write_d   = 1'b1;
        address_d = 2'd1;
        wdata_d   = b_d;
      end
      WR_C: begin
        write_d   = 1'b1;
        address_d = 2'd2;
        wdata_d   = c_d;
      end
      RD_R: begin
        read_d    = 1'b1;
        address_d = 2'd3;
      end
      default: begin
        read_d    = 1'b0;
        write_d   = 1'b0;
        address_d = 2'd0;
        wdata_d   = 32'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);

    // Result lands on the same edge that enters FIN, so it rises with done.
    if (timeout_s) begin
      is_tri_d = 1'b0;
    end else if ((READ_LATENCY == 0) && (state_q == RD_R) && accept_s) begin
      is_tri_d = avm.avm_readdata[0];
    end else if ((READ_LATENCY != 0) && (state_q == CAP)) begin
      is_tri_d = avm.avm_readdata[0];
    end else begin
      is_tri_d = is_tri_q;
    end

    if (start_ok_s) begin
      error_d = 1'b0;
    end else if (timeout_s) begin
      error_d = 1'b1;
    end else begin
      error_d = error_q;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign is_tri            = is_tri_q;
  assign error             = error_q;
  assign avm.avm_read      = read_q;
  assign avm.avm_write     = write_q;
  assign avm.avm_address   = address_q;
  assign avm.avm_writedata = wdata_q;

endmodule

// File: tb/tb_avalon_tri_master.sv
// tb_avalon_tri_master
//   Two masters side by side: dut0 with READ_LATENCY=0 and dut1 with
//   READ_LATENCY=1, each talking to a behavioural triangle-check slave that
//   stores written operands, inserts random or fixed wait states and answers
//   the result read. A per-cycle monitor records accepted transfers and bus
//   rule breaks; each operation is then compared with the expected sequence,
//   latency and result computed from the operands and the applied wait states.
module tb_avalon_tri_master;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  start   = 2'b00;
  logic [31:0] a = 32'd0, b = 32'd0, c = 32'd0;
  logic [1:0]  busy_o, done_o, tri_o, err_o;

  logic [1:0]  m_rd, m_wr;
  logic [1:0]  m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [1:0]  wreq = 2'b00;
  logic [31:0] rdata [2];

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;

  avalon_tri_master_if bus0 ();
  avalon_tri_master_if bus1 ();

  avalon_tri_master #(.READ_LATENCY(0), .TIMEOUT_CYCLES(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .a(a), .b(b), .c(c),
    .busy(busy_o[0]), .done(done_o[0]), .is_tri(tri_o[0]), .error(err_o[0]),
    .avm(bus0.master)
  );

  avalon_tri_master #(.READ_LATENCY(1), .TIMEOUT_CYCLES(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .a(a), .b(b), .c(c),
    .busy(busy_o[1]), .done(done_o[1]), .is_tri(tri_o[1]), .error(err_o[1]),
    .avm(bus1.master)
  );

  assign m_rd[0]    = bus0.avm_read;
  assign m_wr[0]    = bus0.avm_write;
  assign m_addr[0]  = bus0.avm_address;
  assign m_wdata[0] = bus0.avm_writedata;
  assign m_rd[1]    = bus1.avm_read;
  assign m_wr[1]    = bus1.avm_write;
  assign m_addr[1]  = bus1.avm_address;
  assign m_wdata[1] = bus1.avm_writedata;
  assign bus0.avm_waitrequest = wreq[0];
  assign bus1.avm_waitrequest = wreq[1];
  assign bus0.avm_readdata    = rdata[0];
  assign bus1.avm_readdata    = rdata[1];

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Slave / monitor state, one slot per DUT.
  int          w_fix [2];      // <0: random 0..5 waits per transfer
  int          stuck_addr [2]; // address that stalls forever (4 = none)
  int          w_cur [2], st_cnt [2];
  bit          stalled [2], prev_acc_wr [2], rd_pend [2];
  logic        p_rd [2], p_wr [2];
  logic [1:0]  p_addr [2];
  logic [31:0] p_wdata [2];
  logic [31:0] regf [2][3];
  int          viol_ov [2], viol_idle [2], viol_gap [2], viol_stab [2];
  int          done_cnt [2], done_edge [2];
  bit          busy_at_done [2], tri_at_done [2];
  int          log_n [2];
  bit          log_rd [2][8];
  int          log_addr [2][8];
  logic [31:0] log_data [2][8];
  int          log_w [2][8];
  int          n0, e0;

  function automatic logic tri_of(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (({1'b0, x} + {1'b0, y}) > {1'b0, z}) &&
           (({1'b0, y} + {1'b0, z}) > {1'b0, x}) &&
           (({1'b0, x} + {1'b0, z}) > {1'b0, y});
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural slave and bus monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    logic        s;
    logic [31:0] r;
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        stalled[k] = 1'b0; prev_acc_wr[k] = 1'b0; rd_pend[k] = 1'b0;
        wreq[k] = 1'b0; rdata[k] = 32'd0;
      end else begin
        s = m_rd[k] | m_wr[k];
        if (m_rd[k] && m_wr[k]) viol_ov[k]++;
        if (!s && (m_addr[k] != 2'd0 || m_wdata[k] != 32'd0)) viol_idle[k]++;
        if (prev_acc_wr[k] && s) viol_gap[k]++;
        if (stalled[k] && (m_rd[k] != p_rd[k] || m_wr[k] != p_wr[k] ||
                           m_addr[k] != p_addr[k] || m_wdata[k] != p_wdata[k])) viol_stab[k]++;
        if (s && !stalled[k]) begin
          w_cur[k]  = (w_fix[k] < 0) ? int'($urandom_range(0, 5)) : w_fix[k];
          st_cnt[k] = 0;
        end
        if (s && int'(m_addr[k]) == stuck_addr[k]) wreq[k] = 1'b1;
        else wreq[k] = s && (st_cnt[k] < w_cur[k]);
        r = $urandom;
        if (k == 0) begin
          if (m_rd[k] && !wreq[k]) rdata[k] = {r[31:1], tri_of(regf[k][0], regf[k][1], regf[k][2])};
          else rdata[k] = r;
        end else begin
          if (rd_pend[k]) rdata[k] = {r[31:1], tri_of(regf[k][0], regf[k][1], regf[k][2])};
          else rdata[k] = r;
        end
        rd_pend[k] = 1'b0;
        prev_acc_wr[k] = 1'b0;
        if (s && !wreq[k]) begin
          if (log_n[k] < 8) begin
            log_rd[k][log_n[k]]   = m_rd[k];
            log_addr[k][log_n[k]] = int'(m_addr[k]);
            log_data[k][log_n[k]] = m_wdata[k];
            log_w[k][log_n[k]]    = w_cur[k];
            log_n[k]++;
          end
          if (m_wr[k]) begin
            prev_acc_wr[k] = 1'b1;
            if (m_addr[k] != 2'd3) regf[k][m_addr[k]] = m_wdata[k];
          end else begin
            rd_pend[k] = 1'b1;
          end
          stalled[k] = 1'b0;
        end else begin
          stalled[k] = s;
          if (s) st_cnt[k]++;
        end
        p_rd[k] = m_rd[k]; p_wr[k] = m_wr[k]; p_addr[k] = m_addr[k]; p_wdata[k] = m_wdata[k];
        if (done_o[k]) begin
          done_cnt[k]++;
          done_edge[k]    = edge_n;
          busy_at_done[k] = busy_o[k];
          tri_at_done[k]  = tri_o[k];
        end
      end
    end
  end

  task automatic run_op(input int k, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] ic, input int wf, input bit poke);
    int          base, e_acc, exp_lat;
    logic [31:0] ops [3];
    logic        exp_tri;
    ops[0] = ia; ops[1] = ib; ops[2] = ic;
    exp_tri = tri_of(ia, ib, ic);
    @(negedge clk);
    w_fix[k] = wf; a = ia; b = ib; c = ic; start[k] = 1'b1;
    base = done_cnt[k]; log_n[k] = 0;
    viol_ov[k] = 0; viol_idle[k] = 0; viol_gap[k] = 0; viol_stab[k] = 0;
    @(posedge clk); #1;
    e_acc = edge_n; start[k] = 1'b0;
    chk("busy_after_start", busy_o[k], 1'b1);
    chk("error_cleared", err_o[k], 1'b0);
    if (poke) begin
      repeat (2) @(negedge clk);
      a = ~ia; b = ~ib; c = ~ic; start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
    end
    for (int i = 0; i < 200 && done_cnt[k] == base; i++) begin
      @(posedge clk); #1;
    end
    chk("done_seen", done_cnt[k] - base, 1);
    chk("done_pulse_len", done_o[k], 1'b0);
    chk("busy_end", busy_o[k], 1'b0);
    chk("busy_at_done", busy_at_done[k], 1'b1);
    chk("is_tri_at_done", tri_at_done[k], exp_tri);
    chk("is_tri_held", tri_o[k], exp_tri);
    chk("error_low", err_o[k], 1'b0);
    chk("xfer_count", log_n[k], 4);
    exp_lat = k;
    for (int i = 0; i < log_n[k] && i < 4; i++) begin
      exp_lat += log_w[k][i] + (log_rd[k][i] ? 1 : 2);
      chk("xfer_kind", log_rd[k][i], (i == 3));
      chk("xfer_addr", log_addr[k][i], i);
      if (i < 3) chk("xfer_data", log_data[k][i], ops[i]);
    end
    chk("done_latency", done_edge[k] - e_acc, exp_lat);
    repeat (4) @(negedge clk);
    chk("single_done", done_cnt[k] - base, 1);
    chk("strobe_overlap", viol_ov[k], 0);
    chk("idle_bus_zero", viol_idle[k], 0);
    chk("gap_after_write", viol_gap[k], 0);
    chk("stall_stable", viol_stab[k], 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      w_fix[k] = 0; stuck_addr[k] = 4; done_cnt[k] = 0; log_n[k] = 0;
      for (int j = 0; j < 3; j++) regf[k][j] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_outputs", {busy_o[k], done_o[k], tri_o[k], err_o[k], m_rd[k], m_wr[k], m_addr[k]}, 8'd0);
      chk("reset_wdata", m_wdata[k], 32'd0);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed: zero-wait combinational slave, then registered one-wait slave.
    run_op(0, 32'd3, 32'd4, 32'd5, 0, 1'b0);
    run_op(1, 32'd1, 32'd2, 32'd3, 1, 1'b0);

    // Random operands and random wait states on both masters.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 2; k++) begin
        run_op(k, $urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 12), -1, 1'b0);
      end
    end

    // start while busy must be ignored.
    run_op(0, 32'd7, 32'd8, 32'd9, -1, 1'b1);
    run_op(1, 32'd2, 32'd2, 32'd9, 2, 1'b1);

    // Reset during a stalled WR_B.
    stuck_addr[1] = 1; w_fix[1] = 0;
    @(negedge clk);
    a = 32'd10; b = 32'd11; c = 32'd12; start[1] = 1'b1; n0 = done_cnt[1];
    @(negedge clk);
    start[1] = 1'b0;
    for (int i = 0; i < 50 && !(m_wr[1] && m_addr[1] == 2'd1); i++) @(negedge clk);
    chk("wrb_reached", {m_wr[1], m_addr[1]}, 3'b101);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_strobes", {m_rd[1], m_wr[1]}, 2'd0);
    chk("reset_mid_outputs", {busy_o[1], done_o[1], tri_o[1], err_o[1], m_addr[1]}, 6'd0);
    chk("reset_mid_wdata", m_wdata[1], 32'd0);
    @(negedge clk);
    stuck_addr[1] = 4; reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_done_after_abort", done_cnt[1] - n0, 0);
    run_op(1, 32'd6, 32'd7, 32'd8, -1, 1'b0);

`ifdef TRI_MASTER_TIMEOUT_EN
    // Waitrequest stuck on WR_A: abort after 4 stalled cycles.
    run_op(0, 32'd3, 32'd4, 32'd5, 0, 1'b0);
    stuck_addr[0] = 0;
    @(negedge clk);
    a = 32'd3; b = 32'd4; c = 32'd5; start[0] = 1'b1; n0 = done_cnt[0]; log_n[0] = 0;
    @(posedge clk); #1;
    e0 = edge_n; start[0] = 1'b0;
    for (int i = 0; i < 100 && done_cnt[0] == n0; i++) begin
      @(posedge clk); #1;
    end
    chk("timeout_done", done_cnt[0] - n0, 1);
    chk("timeout_latency", done_edge[0] - e0, 4);
    chk("timeout_error", err_o[0], 1'b1);
    chk("timeout_is_tri", tri_o[0], 1'b0);
    chk("timeout_no_xfer", log_n[0], 0);
    stuck_addr[0] = 4;
    run_op(0, 32'd5, 32'd5, 32'd5, 0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
